// File: rtl/fifo_uart_tx.sv
// Drains a show-ahead byte FIFO and serializes each byte as an async UART frame (8N1/8N2).
// Define FIFO_UART_TX_PARITY_EN to insert a parity bit and add the odd_parity port.
module fifo_uart_tx #(
    parameter int unsigned CLKS_PER_BIT = 16,
    parameter int unsigned STOP_BITS    = 1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       enable,
    input  logic       fifo_empty,
    input  logic [7:0] fifo_dout,
    output logic       fifo_rd,
    output logic       txd,
    output logic       busy,
    output logic       frame_done
`ifdef FIFO_UART_TX_PARITY_EN
    ,
    input  logic       odd_parity
`endif
);

    localparam int unsigned BAUD_W = $clog2(CLKS_PER_BIT);
    localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
    localparam logic [BAUD_W-1:0] BAUD_PRE  = BAUD_W'(CLKS_PER_BIT - 2);
    localparam logic [2:0]        STOP_LAST = 3'(STOP_BITS - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP
    } state_t;

    state_t            state_q, state_d;
    logic [BAUD_W-1:0] baud_q, baud_d;
    logic [2:0]        bit_idx_q, bit_idx_d;
    logic [7:0]        shift_q, shift_d;
    logic              txd_q, txd_d;
    logic              busy_q, busy_d;
    logic              fifo_rd_q, fifo_rd_d;
    logic              frame_done_q, frame_done_d;
    logic              bit_end;
`ifdef FIFO_UART_TX_PARITY_EN
    logic              parity_q, parity_d;
`endif

    always_comb begin
        state_d      = state_q;
        baud_d       = baud_q;
        bit_idx_d    = bit_idx_q;
        shift_d      = shift_q;
        txd_d        = txd_q;
        busy_d       = busy_q;
        fifo_rd_d    = 1'b0;
        frame_done_d = 1'b0;
`ifdef FIFO_UART_TX_PARITY_EN
        parity_d     = parity_q;
`endif
        bit_end = (baud_q == BAUD_LAST);

        if (state_q != S_IDLE) begin
            baud_d = bit_end ? '0 : baud_q + 1'b1;
        end

        case (state_q)
            S_IDLE: begin
                if (enable && !fifo_empty) begin
                    shift_d   = fifo_dout;
`ifdef FIFO_UART_TX_PARITY_EN
                    parity_d  = (^fifo_dout) ^ odd_parity;
`endif
                    state_d   = S_START;
                    txd_d     = 1'b0;
                    busy_d    = 1'b1;
                    fifo_rd_d = 1'b1;
                    baud_d    = '0;
                    bit_idx_d = '0;
                end
            end
            S_START: begin
                if (bit_end) begin
                    state_d = S_DATA;
                    txd_d   = shift_q[0];
                end
            end
            S_DATA: begin
                if (bit_end) begin
                    if (bit_idx_q == 3'd7) begin
                        bit_idx_d = '0;
`ifdef FIFO_UART_TX_PARITY_EN
                        state_d   = S_PARITY;
                        txd_d     = parity_q;
`else
                        state_d   = S_STOP;
                        txd_d     = 1'b1;
`endif
                    end else begin
                        // line always carries shift_q[0]; next bit is shift_q[1]
                        shift_d   = shift_q >> 1;
                        txd_d     = shift_q[1];
                        bit_idx_d = bit_idx_q + 3'd1;
                    end
                end
            end
`ifdef FIFO_UART_TX_PARITY_EN
            S_PARITY: begin
                if (bit_end) begin
                    state_d = S_STOP;
                    txd_d   = 1'b1;
                end
            end
`endif
            S_STOP: begin
                // registered, so raise one cycle early to land in the final stop cycle
                frame_done_d = (baud_q == BAUD_PRE) && (bit_idx_q == STOP_LAST);
                if (bit_end) begin
                    if (bit_idx_q == STOP_LAST) begin
                        state_d   = S_IDLE;
                        busy_d    = 1'b0;
                        bit_idx_d = '0;
                    end else begin
                        bit_idx_d = bit_idx_q + 3'd1;
                    end
                end
            end
            default: begin
                state_d = S_IDLE;
                txd_d   = 1'b1;
                busy_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= S_IDLE;
            baud_q       <= '0;
            bit_idx_q    <= '0;
            shift_q      <= '0;
            txd_q        <= 1'b1;
            busy_q       <= 1'b0;
            fifo_rd_q    <= 1'b0;
            frame_done_q <= 1'b0;
`ifdef FIFO_UART_TX_PARITY_EN
            parity_q     <= 1'b0;
`endif
        end else begin
            state_q      <= state_d;
            baud_q       <= baud_d;
            bit_idx_q    <= bit_idx_d;
            shift_q      <= shift_d;
            txd_q        <= txd_d;
            busy_q       <= busy_d;
            fifo_rd_q    <= fifo_rd_d;
            frame_done_q <= frame_done_d;
`ifdef FIFO_UART_TX_PARITY_EN
            parity_q     <= parity_d;
`endif
        end
    end

    assign txd        = txd_q;
    assign busy       = busy_q;
    assign fifo_rd    = fifo_rd_q;
    assign frame_done = frame_done_q;

endmodule

// File: tb/tb_fifo_uart_tx.sv
// Directed bench for fifo_uart_tx (CLKS_PER_BIT=4) with a behavioural show-ahead FIFO.
module tb_fifo_uart_tx;

`ifdef FIFO_UART_TX_PARITY_EN
    localparam int PAR = 1;
`else
    localparam int PAR = 0;
`endif

    logic       clk = 1'b0;
    logic       reset;
    logic       enable;
    logic       fifo_empty;
    logic [7:0] fifo_dout;
    logic       fifo_rd;
    logic       txd;
    logic       busy;
    logic       frame_done;

    int checks = 0;
    int errors = 0;

    logic [7:0] mem [16];
    int wr_cnt = 0;
    int rd_cnt = 0;
    int bad_pops = 0;
    int waited;

    always #5 clk = ~clk;

    assign fifo_empty = (wr_cnt == rd_cnt);
    assign fifo_dout  = mem[rd_cnt[3:0]];

    always @(posedge clk) begin
        if (fifo_rd) begin
            if (wr_cnt == rd_cnt) bad_pops <= bad_pops + 1;
            rd_cnt <= rd_cnt + 1;
        end
    end

    fifo_uart_tx #(.CLKS_PER_BIT(4), .STOP_BITS(1)) dut (
        .clk(clk), .reset(reset), .enable(enable),
        .fifo_empty(fifo_empty), .fifo_dout(fifo_dout), .fifo_rd(fifo_rd),
        .txd(txd), .busy(busy), .frame_done(frame_done)
`ifdef FIFO_UART_TX_PARITY_EN
        , .odd_parity(1'b0)
`endif
    );

`ifdef FIFO_UART_TX_PARITY_EN
    logic       enable_p, empty_p, odd_p, rd_p, txd_p, busy_p, done_p;
    logic [7:0] dout_p;

    fifo_uart_tx #(.CLKS_PER_BIT(4), .STOP_BITS(2)) dut_p (
        .clk(clk), .reset(reset), .enable(enable_p),
        .fifo_empty(empty_p), .fifo_dout(dout_p), .fifo_rd(rd_p),
        .txd(txd_p), .busy(busy_p), .frame_done(done_p), .odd_parity(odd_p)
    );
`endif

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic push(input logic [7:0] b);
        mem[wr_cnt % 16] = b;
        wr_cnt++;
    endtask

    task automatic wait_start(output int n);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!busy && n < 200);
        chk("start_seen", busy, 1);
    endtask

    // Entered at the first cycle of START; leaves one cycle after the frame ends.
    task automatic run_frame(input logic [7:0] b, input int drop_at);
        logic [11:0] bits;
        int nb, fd, rds;
        nb = 10 + PAR;
        bits = '1;
        bits[0] = 1'b0;
        for (int i = 0; i < 8; i++) bits[i+1] = b[i];
        if (PAR != 0) bits[9] = ^b;
        chk("start_rd", fifo_rd, 1);
        chk("start_txd", txd, 0);
        fd = 0;
        rds = 1;
        for (int k = 2; k <= nb * 4; k++) begin
            @(negedge clk);
            if (k == drop_at) enable = 1'b0;
            if (fifo_rd) rds++;
            if (frame_done) fd++;
            if (k % 4 == 2) chk($sformatf("bit%0d_of_%0h", k / 4, b), txd, bits[k/4]);
            if (k == nb * 4) chk("frame_done_last", frame_done, 1);
        end
        chk("frame_done_count", fd, 1);
        chk("rd_count", rds, 1);
        @(negedge clk);
        chk("end_busy", busy, 0);
        chk("end_txd", txd, 1);
    endtask

`ifdef FIFO_UART_TX_PARITY_EN
    task automatic run_par(input logic op, input logic [7:0] b, input logic exp_par);
        logic [11:0] bits;
        int n;
        bits = '1;
        bits[0] = 1'b0;
        for (int i = 0; i < 8; i++) bits[i+1] = b[i];
        bits[9] = exp_par;
        odd_p = op;
        dout_p = b;
        empty_p = 1'b0;
        enable_p = 1'b1;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!busy_p && n < 200);
        chk("par_start_seen", busy_p, 1);
        empty_p = 1'b1;
        for (int k = 2; k <= 48; k++) begin
            @(negedge clk);
            if (k % 4 == 2) chk($sformatf("par_bit%0d_op%0d", k / 4, op), txd_p, bits[k/4]);
            if (k == 48) chk("par_frame_done_48", done_p, 1);
        end
        @(negedge clk);
        chk("par_end_busy", busy_p, 0);
    endtask
`endif

    initial begin
        #2_000_000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1;
        enable = 1'b0;
`ifdef FIFO_UART_TX_PARITY_EN
        enable_p = 1'b0;
        empty_p = 1'b1;
        dout_p = '0;
        odd_p = 1'b0;
`endif
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("rst_txd", txd, 1);
            chk("rst_busy", busy, 0);
            chk("rst_rd", fifo_rd, 0);
        end
        reset = 1'b0;
        @(negedge clk);
        chk("idle_busy", busy, 0);

        // single byte
        enable = 1'b1;
        push(8'hA5);
        wait_start(waited);
        chk("single_wait", waited, 1);
        run_frame(8'hA5, 0);
        chk("single_pops", rd_cnt, 1);

        // back-to-back
        push(8'h00);
        push(8'hFF);
        push(8'h3C);
        wait_start(waited);
        run_frame(8'h00, 0);
        wait_start(waited);
        chk("b2b_gap1", waited, 1);
        run_frame(8'hFF, 0);
        wait_start(waited);
        chk("b2b_gap2", waited, 1);
        run_frame(8'h3C, 0);
        chk("b2b_empty", fifo_empty, 1);
        chk("b2b_txd", txd, 1);
        chk("b2b_pops", rd_cnt, 4);

        // enable gating
        push(8'h11);
        push(8'h22);
        wait_start(waited);
        run_frame(8'h11, 12);
        repeat (8) @(negedge clk);
        chk("gate_busy", busy, 0);
        chk("gate_pops", rd_cnt, 5);
        enable = 1'b1;
        wait_start(waited);
        chk("gate_restart", waited, 1);
        run_frame(8'h22, 0);
        chk("gate_pops2", rd_cnt, 6);

        // reset during DATA bit 3
        push(8'h00);
        wait_start(waited);
        repeat (17) @(negedge clk);
        chk("midrst_pre_txd", txd, 0);
        reset = 1'b1;
        @(negedge clk);
        chk("midrst_txd", txd, 1);
        chk("midrst_busy", busy, 0);
        chk("midrst_rd", fifo_rd, 0);
        reset = 1'b0;
        repeat (3) @(negedge clk);
        chk("midrst_idle", busy, 0);
        chk("midrst_pops", rd_cnt, 7);
        push(8'hC3);
        wait_start(waited);
        chk("midrst_restart", waited, 1);
        run_frame(8'hC3, 0);
        chk("midrst_pops2", rd_cnt, 8);
        chk("no_pop_when_empty", bad_pops, 0);

`ifdef FIFO_UART_TX_PARITY_EN
        run_par(1'b0, 8'h07, 1'b1);
        run_par(1'b1, 8'h07, 1'b0);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
